// File: rtl/serial_mem_responder_if.sv
// Bundle of link pins and memory-port signals for serial_mem_responder.
// Modport slave is the responder side. Modport master is the CPU link plus the memory model side.
//   link_in   : CPU TX pins (idle all-zero)     link_out  : CPU RX pins (idle all-zero)
//   mem_addr  : memory address                 mem_re    : read strobe, data valid next cycle
//   mem_we    : single-cycle write strobe      mem_wdata : write data
//   mem_rdata : read data                      busy      : transaction in progress
//   err_pulse : reserved command or dropped frame
interface serial_mem_responder_if #(
  parameter int unsigned NSHIFT         = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned ADDR_BITS      = 16
);
  localparam int unsigned W = NSHIFT * PAYLOAD_CYCLES;

  logic [NSHIFT-1:0]    link_in;
  logic [NSHIFT-1:0]    link_out;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_re;
  logic                 mem_we;
  logic [W-1:0]         mem_wdata;
  logic [W-1:0]         mem_rdata;
  logic                 busy;
  logic                 err_pulse;

  modport slave (
    input  link_in, mem_rdata,
    output link_out, mem_addr, mem_re, mem_we, mem_wdata, busy, err_pulse
  );

  modport master (
    output link_in, mem_rdata,
    input  link_out, mem_addr, mem_re, mem_we, mem_wdata, busy, err_pulse
  );
endinterface

// File: rtl/serial_mem_responder.sv
// Memory-side responder for the CPU serial link. Receives command frames on link_in
// (start, command, address payload, write-data payload), performs the access on a
// synchronous memory port and serialises read data back on link_out (start + payload).
// Ports: clk, reset (async active-low), bus (serial_mem_responder_if.slave).
// Optional: define SERIAL_MEM_RESPONDER_WRITE_ACK_EN to make writes return an ack reply
// carrying the written address; otherwise writes produce no reply.
// Assumes NSHIFT >= 2 (the command occupies link_in[1:0]).
module serial_mem_responder #(
  parameter int unsigned NSHIFT         = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned ADDR_BITS      = 16,
  parameter int unsigned TURNAROUND     = 1
) (
  input logic                   clk,
  input logic                   reset,
  serial_mem_responder_if.slave bus
);
  localparam int unsigned W       = NSHIFT * PAYLOAD_CYCLES;
  localparam int unsigned CntMax  = (PAYLOAD_CYCLES > TURNAROUND) ? PAYLOAD_CYCLES : TURNAROUND;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] PayLast  = CntW'(PAYLOAD_CYCLES - 1);
  // RD_WAIT already provides the first idle cycle, so TURN covers the rest.
  localparam logic [CntW-1:0] TurnLast = CntW'((TURNAROUND > 1) ? TURNAROUND - 2 : 0);

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StWdata, StWriteMem,
    StRdMem, StRdWait, StTurn, StReplyStart, StReplyData
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [W-1:0]      addr_q, addr_d;
  logic [W-1:0]      data_q, data_d;
  logic [NSHIFT-1:0] link_out_q, link_out_d;
  logic              drop_q, drop_d;
  logic              mem_re, mem_we, err;
  logic              pay_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    drop_d     = drop_q;
    link_out_d = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    err        = 1'b0;
    pay_last   = (cnt_q == PayLast);

    unique case (state_q)
      StIdle: begin
        if (bus.link_in[0]) state_d = StCmd;
      end
      StCmd: begin
        cmd_d   = bus.link_in[1:0];
        cnt_d   = '0;
        state_d = StAddr;
      end
      StAddr: begin
        addr_d = {bus.link_in, addr_q[W-1:NSHIFT]};
        cnt_d  = pay_last ? '0 : cnt_q + CntW'(1);
        if (pay_last) begin
          if (cmd_q[1]) begin
            err     = 1'b1;
            state_d = StIdle;
          end else if (cmd_q[0]) begin
            state_d = StWdata;
          end else begin
            state_d = StRdMem;
          end
        end
      end
      StWdata: begin
        data_d = {bus.link_in, data_q[W-1:NSHIFT]};
        cnt_d  = pay_last ? '0 : cnt_q + CntW'(1);
        if (pay_last) state_d = StWriteMem;
      end
      StWriteMem: begin
        mem_we = 1'b1;
`ifdef SERIAL_MEM_RESPONDER_WRITE_ACK_EN
        state_d = StRdWait;
`else
        state_d = StIdle;
`endif
      end
      StRdMem: begin
        mem_re  = 1'b1;
        state_d = StRdWait;
      end
      StRdWait: begin
`ifdef SERIAL_MEM_RESPONDER_WRITE_ACK_EN
        data_d = cmd_q[0] ? W'(addr_q[ADDR_BITS-1:0]) : bus.mem_rdata;
`else
        data_d = bus.mem_rdata;
`endif
        cnt_d = '0;
        if (TURNAROUND > 1) state_d = StTurn;
        else                state_d = StReplyStart;
      end
      StTurn: begin
        cnt_d = (cnt_q == TurnLast) ? '0 : cnt_q + CntW'(1);
        if (cnt_q == TurnLast) state_d = StReplyStart;
      end
      StReplyStart: begin
        cnt_d   = '0;
        state_d = StReplyData;
      end
      StReplyData: begin
        cnt_d = pay_last ? '0 : cnt_q + CntW'(1);
        if (pay_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // link_out is registered against the next state so the wire lines up with state_q.
    if (state_d == StReplyStart) begin
      link_out_d = NSHIFT'(1);
    end else if (state_d == StReplyData) begin
      link_out_d = data_q[NSHIFT-1:0];
      data_d     = {NSHIFT'(0), data_q[W-1:NSHIFT]};
    end

    // Only outside frame reception can a start be told apart from payload bits.
    // drop_q limits the error to one pulse per busy period.
    if ((state_q inside {StWriteMem, StRdMem, StRdWait, StTurn, StReplyStart, StReplyData})
        && bus.link_in[0] && !drop_q) begin
      err    = 1'b1;
      drop_d = 1'b1;
    end
    if (state_d == StIdle) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      link_out_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      link_out_q <= link_out_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.link_out  = link_out_q;
  assign bus.mem_addr  = addr_q[ADDR_BITS-1:0];
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = data_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_pulse = err;
endmodule
